decoder38_seq: RTL and testbench
================================

// Module: decoder38_seq
// PURPOSE
//   Registered 3-to-8 one-hot decoder, the inverse of the 8-3 encoder path.
//   Direct mode: decodes a handshaked 3-bit code and holds the one-hot output for a fixed time.
//   Scan mode: free-runs an internal code counter to drive a rotating one-hot select,
//   e.g. 8-digit display or LED scan.
//   Sits between control logic and display/select lines.
// PARAMETERS
//   HOLD_CYCLES  2  cycles a direct-mode decode stays on oData (legal >= 1)
//   SCAN_DIV     4  clock cycles per code step in scan mode (legal >= 1)
// PORTS
//   iClk     in   1  clock; all state updates on rising edge
//   iRst_n   in   1  asynchronous, active-low reset
//   iMode    in   1  0 = direct decode, 1 = auto scan
//   iValid   in   1  iData valid (direct mode)
//   iData    in   3  binary code to decode
//   oReady   out  1  block can accept iData this cycle
//   oValid   out  1  oData/oCode carry a live decode
//   oData    out  8  one-hot output, oData[k]=1 iff oCode==k and oValid
//   oCode    out  3  code currently driven on oData
//   oWrap    out  1  one-cycle pulse when scan steps 7 -> 0
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE.
//     oData=8'h00, oCode=3'd0, oValid=0, oReady=1, oWrap=0.
//     Hold and divider counters cleared.
//   All outputs are registered; no combinational path from inputs to outputs.
//   FSM states: IDLE, HOLD, SCAN.
//   IDLE: oReady=1, oValid=0, oData=0. Priority at each edge:
//     - iMode=1 -> SCAN. Next cycle: oCode=0, oData=8'h01, oValid=1, oReady=0.
//       iValid is ignored.
//     - else iValid=1 -> accept -> HOLD. Next cycle: oCode=iData, oData=1<<iData,
//       oValid=1, oReady=0.
//     - else stay in IDLE.
//   HOLD: outputs frozen for exactly HOLD_CYCLES cycles after the accept edge.
//     - Then return to IDLE: oData=0, oValid=0, oReady=1.
//     - iValid and iMode are ignored in HOLD; a mode change takes effect from IDLE.
//     - Back-to-back accepts: one accept every HOLD_CYCLES+1 cycles max.
//   SCAN: a divider counts 0..SCAN_DIV-1.
//     - At terminal count: oCode <= oCode+1 (3-bit wrap), oData rotates left by 1,
//       divider -> 0.
//     - On the 7 -> 0 step, oWrap=1 for exactly the one cycle oData first shows 8'h01.
//     - SCAN_DIV=1: oCode advances every cycle.
//     - iMode=0 sampled in SCAN -> IDLE next cycle. Outputs cleared as in reset,
//       oReady=1, divider cleared, oWrap=0. This applies even mid-divide.
//   Reset asserted in any state: outputs return to reset values immediately
//     (async) and any pending decode is dropped.
//   Invariant: oData is 8'h00 or exactly one-hot; oData==0 iff oValid==0.
// TESTING
//   1. Reset, then idle 5 cycles -> oData=00, oValid=0, oReady=1, oWrap=0 throughout.
//   2. HOLD_CYCLES=2, iValid=1, iData=5 for 1 cycle.
//      -> next 2 cycles: oData=8'h20, oCode=5, oReady=0; then oData=00, oReady=1.
//   3. iValid held high with iData 0..7 stepping on each accept
//      -> oData sequence 01,02,..,80; one accept per 3 cycles; no code skipped.
//   4. SCAN_DIV=4, iMode=1 for 40 cycles.
//      -> oData 01,02,..,80,01, each shown for 4 cycles.
//      -> oWrap pulses once, on the cycle oData returns to 01.
//   5. In SCAN at oCode=3, divider=2, drop iMode.
//      -> next cycle IDLE, oData=00, oReady=1.
//      Re-enter SCAN -> starts at 01 with a full 4-cycle dwell.
//   6. Assert iRst_n=0 mid-HOLD (oData=8'h10) -> oData=00, oReady=1 before the next edge.
//      iMode=1 asserted during HOLD is not acted on until HOLD ends.

Source files
------------

// File: rtl/decoder38_seq.sv
// Registered 3-to-8 one-hot decoder with two operating modes.
// Direct mode decodes a handshaked 3-bit code and holds the one-hot result
// for HOLD_CYCLES cycles; scan mode free-runs a code counter that advances
// every SCAN_DIV cycles, giving a rotating one-hot select for display or LED
// multiplexing. Every output comes straight from a flop.
module decoder38_seq #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned SCAN_DIV    = 4
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iMode,
    input  logic       iValid,
    input  logic [2:0] iData,
    output logic       oReady,
    output logic       oValid,
    output logic [7:0] oData,
    output logic [2:0] oCode,
    output logic       oWrap
);

    // Counter widths, kept at least one bit so the degenerate settings of 1 still elaborate
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DIV_W  = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [7:0]        data_q,  data_d;
    logic [2:0]        code_q,  code_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              wrap_q,  wrap_d;

    // Next-state and next-output decision for all three modes
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        div_d   = div_q;
        data_d  = data_q;
        code_d  = code_q;
        valid_d = valid_q;
        ready_d = ready_q;
        wrap_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (iMode) begin
                    // Scan always starts from code 0 with a fresh dwell; iValid is ignored
                    state_d = SCAN;
                    code_d  = 3'd0;
                    data_d  = 8'h01;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    div_d   = '0;
                end else if (iValid) begin
                    state_d = HOLD;
                    code_d  = iData;
                    data_d  = 8'h01 << iData;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    hold_d  = '0;
                end
            end

            HOLD: begin
                // Inputs are deliberately not looked at until the hold expires
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    code_d  = 3'd0;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            SCAN: begin
                if (!iMode) begin
                    // Leaving scan abandons the current dwell immediately
                    state_d = IDLE;
                    code_d  = 3'd0;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    div_d   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    code_d = code_q + 3'd1;
                    data_d = {data_q[6:0], data_q[7]};
                    wrap_d = (code_q == 3'd7);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                hold_d  = '0;
                div_d   = '0;
                code_d  = 3'd0;
                data_d  = 8'h00;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            div_q   <= '0;
            data_q  <= 8'h00;
            code_q  <= 3'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            div_q   <= div_d;
            data_q  <= data_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            wrap_q  <= wrap_d;
        end
    end

    assign oReady = ready_q;
    assign oValid = valid_q;
    assign oData  = data_q;
    assign oCode  = code_q;
    assign oWrap  = wrap_q;

    // oData is empty exactly when nothing is valid, otherwise one-hot at oCode
    a_onehot: assert property (@(posedge iClk) disable iff (!iRst_n)
        (oValid ? (oData == (8'h01 << oCode)) : (oData == 8'h00)));

    // Ready and valid are never both asserted
    a_ready_valid: assert property (@(posedge iClk) disable iff (!iRst_n)
        !(oReady && oValid));

endmodule

// File: tb/tb_decoder38_seq.sv
// Directed bench for decoder38_seq with HOLD_CYCLES=2, SCAN_DIV=4.
module tb_decoder38_seq;

    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       valid_in;
    logic [2:0] data_in;
    logic       ready;
    logic       valid_out;
    logic [7:0] data_out;
    logic [2:0] code_out;
    logic       wrap;

    int n_checks;
    int n_fail;

    // Hand-written one-hot table indexed by code
    logic [7:0] onehot_tab [8];

    decoder38_seq #(
        .HOLD_CYCLES(2),
        .SCAN_DIV   (4)
    ) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .iMode (mode),
        .iValid(valid_in),
        .iData (data_in),
        .oReady(ready),
        .oValid(valid_out),
        .oData (data_out),
        .oCode (code_out),
        .oWrap (wrap)
    );

    // Observation vectors: full {data,code,valid,ready,wrap} and one without code
    logic [13:0] obs;
    logic [10:0] obs_nc;
    assign obs    = {data_out, code_out, valid_out, ready, wrap};
    assign obs_nc = {data_out, valid_out, ready, wrap};

    function automatic logic [13:0] pk(input logic [7:0] d, input logic [2:0] c,
                                       input logic v, input logic r, input logic w);
        return {d, c, v, r, w};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mode     = 1'b0;
        valid_in = 1'b0;
        data_in  = 3'd0;
        #12;
        n_checks++;
        if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: got %h expected %h", i, obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_direct_single();
        valid_in = 1'b1;
        data_in  = 3'd5;
        tick();
        valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs !== pk(8'h20, 3'd5, 1'b1, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL direct_hold_%0d: got %h expected %h", i, obs, pk(8'h20, 3'd5, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        n_checks++;
        if (obs_nc !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL direct_release: got %h expected %h", obs_nc, {8'h00, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        valid_in = 1'b1;
        data_in  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < 2; h++) begin
                tick();
                n_checks++;
                if (obs !== pk(onehot_tab[k], 3'(k), 1'b1, 1'b0, 1'b0)) begin
                    n_fail++;
                    $display("FAIL b2b_code%0d_hold%0d: got %h expected %h", k, h, obs,
                             pk(onehot_tab[k], 3'(k), 1'b1, 1'b0, 1'b0));
                end
            end
            tick();
            n_checks++;
            if (obs_nc !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_gap%0d: got %h expected %h", k, obs_nc, {8'h00, 1'b0, 1'b1, 1'b0});
            end
            data_in = 3'(k + 1);
            if (k == 7) valid_in = 1'b0;
        end
    endtask

    task automatic test_scan();
        int wraps;
        logic [2:0] ec;
        wraps    = 0;
        mode     = 1'b1;
        valid_in = 1'b1;
        data_in  = 3'd6;
        for (int c = 0; c < 40; c++) begin
            tick();
            valid_in = 1'b0;
            ec = 3'((c / 4) % 8);
            if (wrap === 1'b1) wraps++;
            n_checks++;
            if (obs !== pk(onehot_tab[ec], ec, 1'b1, 1'b0, 1'(c == 32))) begin
                n_fail++;
                $display("FAIL scan_cycle%0d: got %h expected %h", c, obs,
                         pk(onehot_tab[ec], ec, 1'b1, 1'b0, 1'(c == 32)));
            end
        end
        n_checks++;
        if (wraps !== 1) begin
            n_fail++;
            $display("FAIL scan_wrap_count: got %0d expected 1", wraps);
        end
        mode = 1'b0;
        tick();
        n_checks++;
        if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL scan_exit: got %h expected %h", obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
        end
    endtask

    task automatic test_scan_abort();
        mode = 1'b1;
        for (int c = 0; c < 15; c++) tick();
        n_checks++;
        if (obs !== pk(8'h08, 3'd3, 1'b1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_pre: got %h expected %h", obs, pk(8'h08, 3'd3, 1'b1, 1'b0, 1'b0));
        end
        mode = 1'b0;
        tick();
        n_checks++;
        if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL abort_idle: got %h expected %h", obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
        end
        mode = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (obs !== pk((c < 4) ? 8'h01 : 8'h02, (c < 4) ? 3'd0 : 3'd1, 1'b1, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL reenter_cycle%0d: got %h expected %h", c, obs,
                         pk((c < 4) ? 8'h01 : 8'h02, (c < 4) ? 3'd0 : 3'd1, 1'b1, 1'b0, 1'b0));
            end
        end
        mode = 1'b0;
        tick();
        n_checks++;
        if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reenter_exit: got %h expected %h", obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
        end
    endtask

    task automatic test_hold_mode_and_reset();
        // Mode request raised during HOLD waits for the hold to finish
        valid_in = 1'b1;
        data_in  = 3'd4;
        tick();
        valid_in = 1'b0;
        mode     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs !== pk(8'h10, 3'd4, 1'b1, 1'b0, 1'b0)) begin
                n_fail++;
                $display("FAIL hold_ignores_mode_%0d: got %h expected %h", i, obs, pk(8'h10, 3'd4, 1'b1, 1'b0, 1'b0));
            end
            tick();
        end
        n_checks++;
        if (obs_nc !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_end_idle: got %h expected %h", obs_nc, {8'h00, 1'b0, 1'b1, 1'b0});
        end
        tick();
        n_checks++;
        if (obs !== pk(8'h01, 3'd0, 1'b1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL hold_then_scan: got %h expected %h", obs, pk(8'h01, 3'd0, 1'b1, 1'b0, 1'b0));
        end
        mode = 1'b0;
        tick();

        // Asynchronous reset in the middle of a hold
        valid_in = 1'b1;
        data_in  = 3'd4;
        tick();
        valid_in = 1'b0;
        n_checks++;
        if (obs !== pk(8'h10, 3'd4, 1'b1, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL rst_hold_pre: got %h expected %h", obs, pk(8'h10, 3'd4, 1'b1, 1'b0, 1'b0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL rst_async: got %h expected %h", obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0)) begin
                n_fail++;
                $display("FAIL rst_dropped_%0d: got %h expected %h", i, obs, pk(8'h00, 3'd0, 1'b0, 1'b1, 1'b0));
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        onehot_tab[0] = 8'h01;
        onehot_tab[1] = 8'h02;
        onehot_tab[2] = 8'h04;
        onehot_tab[3] = 8'h08;
        onehot_tab[4] = 8'h10;
        onehot_tab[5] = 8'h20;
        onehot_tab[6] = 8'h40;
        onehot_tab[7] = 8'h80;

        test_reset();
        test_direct_single();
        test_back_to_back();
        test_scan();
        test_scan_abort();
        test_hold_mode_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
